// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the store buffer: entry record and word-index helper.
package store_buffer_pkg;

    localparam int SB_DEPTH    = 4;
    localparam int SB_IDX_BITS = 2;

    typedef struct packed {
        logic        valid;
        logic [29:0] word_addr;
        logic [31:0] data;
    } sb_entry_t;

    function automatic logic [29:0] word_idx(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/sb_forward_match.sv
// Youngest-hit select: scans pending entries from oldest (head) to youngest,
// so the last match found wins.
module sb_forward_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH    = SB_DEPTH,
    parameter int IDX_BITS = SB_IDX_BITS
) (
    input  sb_entry_t           entries_i [DEPTH],
    input  logic [IDX_BITS-1:0] head_i,
    input  logic [IDX_BITS:0]   count_i,
    input  logic [29:0]         word_i,
    output logic                hit_o,
    output logic [31:0]         data_o
);

    logic [DEPTH-1:0]    match;
    logic [IDX_BITS-1:0] idx;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign match[gi] = entries_i[gi].valid && (entries_i[gi].word_addr == word_i);
    end

    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + IDX_BITS'(i);
            if (((IDX_BITS+1)'(i) < count_i) && match[idx]) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Word-granular FIFO store buffer: queues stores, drains them when the CPU leaves
// the memory port idle, and forwards loads from the youngest matching pending store.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH    = SB_DEPTH,
    parameter int IDX_BITS = SB_IDX_BITS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        empty,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam logic [IDX_BITS-1:0] PTR_ONE   = IDX_BITS'(1);
    localparam logic [IDX_BITS:0]   CNT_ONE   = (IDX_BITS+1)'(1);
    localparam logic [IDX_BITS:0]   CNT_FULL  = (IDX_BITS+1)'(DEPTH);

    sb_entry_t           entry_q [DEPTH];
    logic [IDX_BITS-1:0] head_q, head_d;
    logic [IDX_BITS-1:0] tail_q, tail_d;
    logic [IDX_BITS:0]   count_q, count_d;

    logic        full;
    logic        read_eff;
    logic        drain;
    logic        enq;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    // A simultaneous read+write is handled as a plain store.
    assign read_eff = cpu_read && !cpu_write && !reset;
    assign drain    = !reset && !read_eff && !empty && (!cpu_write || full);
    assign enq      = !reset && cpu_write && !full;
    assign stall    = !reset && cpu_write && full;

    sb_forward_match #(
        .DEPTH    (DEPTH),
        .IDX_BITS (IDX_BITS)
    ) u_fwd (
        .entries_i (entry_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .word_i    (word_idx(cpu_addr)),
        .hit_o     (fwd_hit),
        .data_o    (fwd_data)
    );

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = entry_q[head_q].data;
        cpu_rdata = '0;
        if (read_eff) begin
            mem_read  = 1'b1;
            cpu_rdata = fwd_hit ? fwd_data : mem_rdata;
        end else if (drain) begin
            mem_write = 1'b1;
            mem_addr  = {entry_q[head_q].word_addr, 2'b00};
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            tail_d  = tail_q + PTR_ONE;
            count_d = count_q + CNT_ONE;
        end
        if (drain) begin
            head_d  = head_q + PTR_ONE;
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Only valid bits are reset; stale data behind a cleared valid is never observed.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i].valid <= 1'b0;
            end
        end else begin
            if (enq) begin
                entry_q[tail_q] <= '{valid: 1'b1, word_addr: word_idx(cpu_addr), data: cpu_wdata};
            end
            if (drain) begin
                entry_q[head_q].valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table, then queue-model-checked wrap and random traffic.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] K     = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_read, cpu_write;
    logic        stall, empty;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Memory returns a recognisable function of the address it is given.
    assign mem_rdata = mem_addr ^ K;

    store_buffer #(.DEPTH(DEPTH), .IDX_BITS(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .empty     (empty),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic        rst, rd, wr;
        logic [31:0] addr, wdata;
        logic        e_stall, e_empty, e_mw, e_mr;
        logic [31:0] e_maddr, e_mwdata, e_rdata;
    } vec_t;

    typedef struct {
        logic [29:0] w;
        logic [31:0] d;
    } pend_t;

    vec_t  vecs[$];
    pend_t pq[$];

    function automatic vec_t mk(input logic rst, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic st, input logic em, input logic mw, input logic mr,
                                input logic [31:0] maddr, input logic [31:0] mwdata,
                                input logic [31:0] rdata);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.e_stall = st; v.e_empty = em; v.e_mw = mw; v.e_mr = mr;
        v.e_maddr = maddr; v.e_mwdata = mwdata; v.e_rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        reset = rst; cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wdata;
    endtask

    // Called at the negedge; reset cycles only constrain stall and mem_write.
    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, v.e_stall});
        chk({tag, ".mem_write"}, {31'd0, mem_write}, {31'd0, v.e_mw});
        if (!v.rst) begin
            chk({tag, ".empty"}, {31'd0, empty}, {31'd0, v.e_empty});
            chk({tag, ".mem_read"}, {31'd0, mem_read}, {31'd0, v.e_mr});
            chk({tag, ".mem_addr"}, mem_addr, v.e_maddr);
            chk({tag, ".cpu_rdata"}, cpu_rdata, v.e_rdata);
            if (v.e_mw) chk({tag, ".mem_wdata"}, mem_wdata, v.e_mwdata);
        end
        $display("txn %s rst=%0b rd=%0b wr=%0b addr=%08h wd=%08h | st=%0b em=%0b mw=%0b mr=%0b ma=%08h md=%08h rd=%08h",
                 tag, v.rst, v.rd, v.wr, v.addr, v.wdata, stall, empty, mem_write, mem_read,
                 mem_addr, mem_wdata, cpu_rdata);
    endtask

    // One cycle against the queue model: expectations from the pending-store list.
    task automatic model_cycle(input string tag, input logic rst, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata);
        vec_t  v;
        logic  full, rd_eff, do_drain, do_enq;
        pend_t p;
        full   = (pq.size() == DEPTH);
        rd_eff = rd && !wr;
        v = mk(rst, rd, wr, addr, wdata, !rst && wr && full, pq.size() == 0,
               1'b0, 1'b0, addr, 32'd0, 32'd0);
        do_drain = 1'b0;
        do_enq   = 1'b0;
        if (!rst) begin
            if (rd_eff) begin
                v.e_mr    = 1'b1;
                v.e_rdata = addr ^ K;
                foreach (pq[i]) if (pq[i].w == addr[31:2]) v.e_rdata = pq[i].d;
            end else if (pq.size() > 0 && (!wr || full)) begin
                do_drain   = 1'b1;
                v.e_mw     = 1'b1;
                v.e_maddr  = {pq[0].w, 2'b00};
                v.e_mwdata = pq[0].d;
            end
            do_enq = wr && !full;
        end
        drive(rst, rd, wr, addr, wdata);
        @(negedge clk);
        check_outs(tag, v);
        @(posedge clk); #1;
        if (rst) pq.delete();
        else begin
            if (do_drain) void'(pq.pop_front());
            if (do_enq) begin
                p.w = addr[31:2];
                p.d = wdata;
                pq.push_back(p);
            end
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;

        //             rst rd wr addr    wdata         st em mw mr maddr   mwdata        rdata
        vecs.push_back(mk(1, 0, 0, 32'h00, 32'h0,        0, 1, 0, 0, 32'h00, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 1, 0, 0, 32'h10, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h00, 32'h0,        0, 0, 1, 0, 32'h10, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h00, 32'h0,        0, 1, 0, 0, 32'h00, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 1, 32'h20, 32'hA,        0, 1, 0, 0, 32'h20, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 1, 32'h20, 32'hB,        0, 0, 0, 0, 32'h20, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h20, 32'h0,        0, 0, 0, 1, 32'h20, 32'h0,        32'hB));
        vecs.push_back(mk(0, 1, 0, 32'h22, 32'h0,        0, 0, 0, 1, 32'h22, 32'h0,        32'hB));
        vecs.push_back(mk(0, 0, 0, 32'h00, 32'h0,        0, 0, 1, 0, 32'h20, 32'hA,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h00, 32'h0,        0, 0, 1, 0, 32'h20, 32'hB,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h00, 32'h0,        0, 1, 0, 0, 32'h00, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 1, 32'h00, 32'h100,      0, 1, 0, 0, 32'h00, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 1, 32'h04, 32'h101,      0, 0, 0, 0, 32'h04, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 1, 32'h08, 32'h102,      0, 0, 0, 0, 32'h08, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 1, 32'h0C, 32'h103,      0, 0, 0, 0, 32'h0C, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 1, 32'h10, 32'h104,      1, 0, 1, 0, 32'h00, 32'h100,      32'h0));
        vecs.push_back(mk(0, 0, 1, 32'h10, 32'h104,      0, 0, 0, 0, 32'h10, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h40, 32'h0,        0, 0, 0, 1, 32'h40, 32'h0,        32'hC0DE0040));
        vecs.push_back(mk(0, 1, 0, 32'h08, 32'h0,        0, 0, 0, 1, 32'h08, 32'h0,        32'h102));
        vecs.push_back(mk(1, 0, 0, 32'h00, 32'h0,        0, 0, 0, 0, 32'h00, 32'h0,        32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h00, 32'h0,        0, 1, 0, 0, 32'h00, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h04, 32'h0,        0, 1, 0, 1, 32'h04, 32'h0,        32'hC0DE0004));
        vecs.push_back(mk(0, 1, 0, 32'h10, 32'h0,        0, 1, 0, 1, 32'h10, 32'h0,        32'hC0DE0010));
        vecs.push_back(mk(0, 1, 1, 32'h30, 32'h55,       0, 1, 0, 0, 32'h30, 32'h0,        32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h30, 32'h0,        0, 0, 0, 1, 32'h30, 32'h0,        32'h55));
        vecs.push_back(mk(0, 0, 0, 32'h00, 32'h0,        0, 0, 1, 0, 32'h30, 32'h55,       32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h00, 32'h0,        0, 1, 0, 0, 32'h00, 32'h0,        32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i]);
            @(posedge clk); #1;
        end

        // Three pending stores discarded by a one-cycle reset.
        model_cycle("rs", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++)
            model_cycle("rs_st", 1'b0, 1'b0, 1'b1, 32'h200 + 32'(i * 4), 32'h700 + 32'(i));
        model_cycle("rs_rst", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++)
            model_cycle("rs_ld", 1'b0, 1'b1, 1'b0, 32'h200 + 32'(i * 4), 32'h0);

        // 2*DEPTH stores with irregular idle gaps; drain order must cross the pointer wrap.
        for (int i = 0; i < 2 * DEPTH; i++) begin
            model_cycle("wrap_st", 1'b0, 1'b0, 1'b1, 32'h100 + 32'(i * 4), 32'hA000 + 32'(i));
            if (i % 3 == 2) model_cycle("wrap_idle", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        for (int i = 0; i < 2 * DEPTH; i++)
            model_cycle("wrap_drain", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Randomized traffic over a small address window to provoke forwarding hits.
        for (int i = 0; i < 600; i++) begin
            logic        r_rst, r_rd, r_wr;
            logic [31:0] r_addr, r_data;
            int          op;
            op     = $urandom_range(0, 99);
            r_rst  = (op == 0);
            r_wr   = (op >= 1 && op < 50);
            r_rd   = (op >= 40 && op < 75);
            r_addr = 32'($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3));
            r_data = $urandom;
            model_cycle("rand", r_rst, r_rd, r_wr, r_addr, r_data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
